testbench_quiesce_monitor: RTL and testbench
============================================

Name: testbench_quiesce_monitor

Overview:
- Synthesizable DUT-side companion to the simulation clock/reset generator.
- Consumes `clock`, `reset` and `initFlag`, and tracks outstanding memory traffic and commit progress.
- Produces the `idle` signal the generator polls before `$finish`.
- Also produces an 8-bit watchdog status byte with the same encoding as the cosim watchdog: 0 = continue, 255 = quit, anything else = error. The generator or an assertion can then cross-check hardware against DPI.

Parameters:
- CNT_W, 8: width of each outstanding-transaction counter.
- IDLE_HOLD, 4: consecutive quiet cycles required before `idle` asserts (valid range 1..255).
- TIMEOUT, 10000: maximum cycles between two `progress` pulses in RUN (32-bit compare).
- DRAIN_TIMEOUT, 10000: maximum cycles spent in DRAIN waiting for `idle` (32-bit compare).

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- initFlag  in  1  high during the init window; all events are ignored while high.
- rd_issue  in  1  read request accepted this cycle.
- rd_done  in  1  read response completed this cycle.
- wr_issue  in  1  write request accepted this cycle.
- wr_done  in  1  write response completed this cycle.
- progress  in  1  instruction commit or other forward-progress pulse.
- quit_req  in  1  program signalled exit (level or pulse; sampled once).
- idle  out  1  no outstanding traffic for IDLE_HOLD cycles.
- status  out  8  0 continue, 255 quit done, 1 watchdog timeout, 2 counter overflow, 3 counter underflow, 4 drain timeout.
- rd_outstanding  out  CNT_W  current read count.
- wr_outstanding  out  CNT_W  current write count.

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is synchronous and active-high; it is sampled only on the rising edge of `clock`.
  - Reset, including mid-operation, sets: state INIT, both counters 0, quiet_cnt 0, wd_cnt 0, drain_cnt 0, `idle` 0, `status` 0.
- States: INIT, RUN, DRAIN, DONE, ERROR.
  - INIT: all inputs ignored. Moves to RUN on the first edge where `initFlag` is 0.
  - RUN: `quit_req`=1 moves to DRAIN. If `idle` is already 1 in that same cycle, moves directly to DONE instead.
  - DRAIN: `idle`=1 moves to DONE. drain_cnt increments every cycle; reaching DRAIN_TIMEOUT moves to ERROR with status 4.
  - DONE and ERROR are sticky until reset. Counters keep tracking in DONE; they freeze in ERROR.
- Outstanding counters (one per direction, RUN/DRAIN/DONE only):
  - issue and done together: count unchanged.
  - issue alone: +1. If the count is already 2^CNT_W-1, go to ERROR with status 2.
  - done alone: -1. If the count is 0, go to ERROR with status 3.
- Quiet and idle:
  - A cycle is "quiet" when both counts are 0 and none of the four issue/done inputs is high.
  - quiet_cnt increments on each quiet cycle, saturates at IDLE_HOLD, and clears to 0 on any non-quiet cycle.
  - `idle` = (quiet_cnt == IDLE_HOLD) and state is not INIT or ERROR. It is driven from registers (no input-to-output combinational path).
  - Latency: if the last activity is sampled at edge k, `idle` is high after edge k+IDLE_HOLD.
- Watchdog (RUN only):
  - wd_cnt clears on `progress` and increments otherwise.
  - When wd_cnt reaches TIMEOUT, go to ERROR with status 1.
  - `progress` in the same cycle as the threshold wins (no error).
  - wd_cnt is frozen in DRAIN and DONE.
- Status:
  - 0 in INIT, RUN and DRAIN; 255 in DONE; the error code in ERROR.
  - If several errors occur on the same edge, the lowest nonzero code wins.
  - `status` is registered and changes on the same edge as the state transition.

Decomposition:
- Package `t1_quiesce_pkg` holds:
  - the state enum (INIT, RUN, DRAIN, DONE, ERROR);
  - the status code constants (ST_CONTINUE=0, ST_TIMEOUT=1, ST_OVERFLOW=2, ST_UNDERFLOW=3, ST_DRAIN_TIMEOUT=4, ST_QUIT=255).
- One sub-module, `outstanding_counter`, instantiated twice (read and write):
  - inputs: inc, dec, enable;
  - outputs: count, overflow_err, underflow_err.

Test Plan:
- Init gating: reset high for 5 cycles, `initFlag` high for 2 more cycles with `rd_issue` pulsed during them -> rd_outstanding stays 0, `idle` 0. RUN is entered on the first edge with `initFlag`=0; `idle` rises 4 cycles later.
- Traffic balance: 3 rd_issue pulses, then one cycle with rd_issue and rd_done together, then 3 rd_done pulses -> rd_outstanding reads 1, 2, 3, 3, 2, 1, 0. `idle` is 0 throughout and rises exactly 4 cycles after the last rd_done.
- Clean quit: `quit_req` raised while wr_outstanding=2, two wr_done pulses follow -> state DRAIN; `status` becomes 255 on the edge after `idle` rises (4 quiet cycles later) and holds 255.
- Watchdog: TIMEOUT=100, no `progress` for 100 cycles in RUN -> `status` 1, state ERROR. Repeating with `progress` on cycle 100 -> `status` stays 0.
- Counter errors: rd_done with count 0 -> `status` 3. With CNT_W=2, 4 wr_issue pulses -> `status` 2. Both errors on the same edge -> `status` 2.
- Reset mid-DRAIN: assert `reset` while wr_outstanding=5 in DRAIN -> on the next edge all counters 0, `status` 0, `idle` 0, state INIT.

Source files
------------

// File: rtl/t1_quiesce_pkg.sv
// t1_quiesce_pkg: shared state encoding and watchdog status codes for the quiesce monitor.
package t1_quiesce_pkg;
  typedef enum logic [2:0] {INIT, RUN, DRAIN, DONE, ERROR} state_e;
  localparam logic [7:0] ST_CONTINUE      = 8'd0;
  localparam logic [7:0] ST_TIMEOUT       = 8'd1;
  localparam logic [7:0] ST_OVERFLOW      = 8'd2;
  localparam logic [7:0] ST_UNDERFLOW     = 8'd3;
  localparam logic [7:0] ST_DRAIN_TIMEOUT = 8'd4;
  localparam logic [7:0] ST_QUIT          = 8'd255;
endpackage

// File: rtl/testbench_quiesce_monitor_outstanding_counter.sv
// outstanding_counter: up/down count of in-flight transactions with overflow/underflow flags.
module outstanding_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             overflow_err,
  output logic             underflow_err
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb begin
    overflow_err  = enable && inc && !dec && (count_q == '1);
    underflow_err = enable && dec && !inc && (count_q == '0);
    count_d = count_q;
    if (enable && !overflow_err && !underflow_err && (inc != dec))
      count_d = inc ? count_q + 1'b1 : count_q - 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/testbench_quiesce_monitor.sv
// testbench_quiesce_monitor: tracks outstanding traffic and progress, reports idle and a watchdog status byte.
module testbench_quiesce_monitor
  import t1_quiesce_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int IDLE_HOLD     = 4,
  parameter int TIMEOUT       = 10000,
  parameter int DRAIN_TIMEOUT = 10000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             initFlag,
  input  logic             rd_issue,
  input  logic             rd_done,
  input  logic             wr_issue,
  input  logic             wr_done,
  input  logic             progress,
  input  logic             quit_req,
  output logic             idle,
  output logic [7:0]       status,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic [CNT_W-1:0] wr_outstanding
);
  state_e      state_q, state_d;
  logic [7:0]  quiet_q, quiet_d, status_q, status_d, err_code;
  logic [31:0] wd_q, wd_d, drain_q, drain_d;
  logic        en, act, quiet, rd_ovf, rd_unf, wr_ovf, wr_unf, wd_to, dr_to;
  assign en  = state_q inside {RUN, DRAIN, DONE};
  assign act = state_q inside {RUN, DRAIN};
  outstanding_counter #(.CNT_W(CNT_W)) u_rd (
    .clock(clock), .reset(reset), .inc(rd_issue), .dec(rd_done), .enable(en),
    .count(rd_outstanding), .overflow_err(rd_ovf), .underflow_err(rd_unf)
  );
  outstanding_counter #(.CNT_W(CNT_W)) u_wr (
    .clock(clock), .reset(reset), .inc(wr_issue), .dec(wr_done), .enable(en),
    .count(wr_outstanding), .overflow_err(wr_ovf), .underflow_err(wr_unf)
  );
  assign idle   = (quiet_q == 8'(IDLE_HOLD)) && (state_q != INIT) && (state_q != ERROR);
  assign status = status_q;
  always_comb begin
    quiet    = (rd_outstanding == '0) && (wr_outstanding == '0) && !(rd_issue || rd_done || wr_issue || wr_done);
    quiet_d  = !en ? quiet_q : !quiet ? 8'd0 : (quiet_q == 8'(IDLE_HOLD)) ? quiet_q : quiet_q + 8'd1;
    wd_to    = (state_q == RUN) && !progress && (wd_q + 32'd1 >= 32'(TIMEOUT));
    dr_to    = (state_q == DRAIN) && (drain_q + 32'd1 >= 32'(DRAIN_TIMEOUT));
    // Lowest nonzero code wins when several errors coincide.
    err_code = wd_to ? ST_TIMEOUT :
               (act && (rd_ovf || wr_ovf)) ? ST_OVERFLOW :
               (act && (rd_unf || wr_unf)) ? ST_UNDERFLOW :
               dr_to ? ST_DRAIN_TIMEOUT : ST_CONTINUE;
    wd_d     = (state_q != RUN) ? wd_q : progress ? 32'd0 : wd_q + 32'd1;
    drain_d  = (state_q == DRAIN) ? drain_q + 32'd1 : drain_q;
    state_d  = state_q;
    status_d = status_q;
    if (state_q == INIT) state_d = initFlag ? INIT : RUN;
    else if (err_code != ST_CONTINUE) begin
      state_d  = ERROR;
      status_d = err_code;
    end else if (state_q == RUN && quit_req) begin
      state_d  = idle ? DONE : DRAIN;
      status_d = idle ? ST_QUIT : ST_CONTINUE;
    end else if (state_q == DRAIN && idle) begin
      state_d  = DONE;
      status_d = ST_QUIT;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INIT;
      quiet_q  <= '0;
      wd_q     <= '0;
      drain_q  <= '0;
      status_q <= ST_CONTINUE;
    end else begin
      state_q  <= state_d;
      quiet_q  <= quiet_d;
      wd_q     <= wd_d;
      drain_q  <= drain_d;
      status_q <= status_d;
    end
  end
endmodule

// File: tb/tb_testbench_quiesce_monitor.sv
// tb_testbench_quiesce_monitor: directed table, corner sequences and a randomized reference-model run.
module tb_testbench_quiesce_monitor;
  import t1_quiesce_pkg::*;
  logic clock = 0, reset = 1, initFlag = 1;
  logic rd_issue = 0, rd_done = 0, wr_issue = 0, wr_done = 0, progress = 1, quit_req = 0;
  logic idle_m, idle_w, idle_c;
  logic [7:0] st_m, st_w, st_c, rd_m, wr_m, rd_w, wr_w;
  logic [1:0] rd_c, wr_c;
  int vectors = 0, miscompares = 0;
  always #5 clock = ~clock;

  testbench_quiesce_monitor dut (
    .clock(clock), .reset(reset), .initFlag(initFlag), .rd_issue(rd_issue), .rd_done(rd_done),
    .wr_issue(wr_issue), .wr_done(wr_done), .progress(progress), .quit_req(quit_req),
    .idle(idle_m), .status(st_m), .rd_outstanding(rd_m), .wr_outstanding(wr_m));
  testbench_quiesce_monitor #(.TIMEOUT(100), .DRAIN_TIMEOUT(20)) dut_w (
    .clock(clock), .reset(reset), .initFlag(initFlag), .rd_issue(rd_issue), .rd_done(rd_done),
    .wr_issue(wr_issue), .wr_done(wr_done), .progress(progress), .quit_req(quit_req),
    .idle(idle_w), .status(st_w), .rd_outstanding(rd_w), .wr_outstanding(wr_w));
  testbench_quiesce_monitor #(.CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .initFlag(initFlag), .rd_issue(rd_issue), .rd_done(rd_done),
    .wr_issue(wr_issue), .wr_done(wr_done), .progress(progress), .quit_req(quit_req),
    .idle(idle_c), .status(st_c), .rd_outstanding(rd_c), .wr_outstanding(wr_c));

  typedef struct {
    bit ini, ri, rd, wi, wd, pg, q;
    int e_rd, e_wr, e_idle, e_st;
  } vec_t;
  vec_t tbl[29];

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    {rd_issue, rd_done, wr_issue, wr_done, quit_req} = '0;
    progress = 1;
  endtask

  task automatic start();
    clr();
    reset = 1;
    initFlag = 1;
    repeat (2) tick();
    reset = 0;
    initFlag = 0;
    tick();
  endtask

  // Reference model: phases 0 INIT, 1 RUN, 2 DRAIN, 3 DONE, 4 ERROR; quiet run length kept unsaturated.
  localparam int H = 4, MAXC = 255, T = 10000, DT = 10000;
  int m_ph, m_rd, m_wr, m_ql, m_wd, m_dr, m_st;

  task automatic model_reset();
    {m_ph, m_rd, m_wr, m_ql, m_wd, m_dr, m_st} = '0;
  endtask

  function automatic bit model_idle();
    return m_ql >= H && m_ph >= 1 && m_ph <= 3;
  endfunction

  task automatic model_step(bit ini, bit ri, bit rdn, bit wi, bit wdn, bit pg, bit q);
    bit idle_now, ro, ru, wo, wu, busy;
    int e;
    idle_now = model_idle();
    if (m_ph == 0) begin
      if (!ini) m_ph = 1;
      return;
    end
    if (m_ph == 4) return;
    ro = ri && !rdn && m_rd == MAXC;
    ru = rdn && !ri && m_rd == 0;
    wo = wi && !wdn && m_wr == MAXC;
    wu = wdn && !wi && m_wr == 0;
    busy = m_rd != 0 || m_wr != 0 || ri || rdn || wi || wdn;
    e = 0;
    if (m_ph == 1 && !pg && m_wd + 1 >= T) e = 1;
    else if (m_ph != 3 && (ro || wo)) e = 2;
    else if (m_ph != 3 && (ru || wu)) e = 3;
    else if (m_ph == 2 && m_dr + 1 >= DT) e = 4;
    if (!ro && !ru) m_rd += int'(ri) - int'(rdn);
    if (!wo && !wu) m_wr += int'(wi) - int'(wdn);
    m_ql = busy ? 0 : m_ql + 1;
    if (m_ph == 1) m_wd = pg ? 0 : m_wd + 1;
    if (m_ph == 2) m_dr++;
    if (e != 0) begin
      m_ph = 4;
      m_st = e;
    end else if (m_ph == 1 && q) begin
      m_ph = idle_now ? 3 : 2;
      if (idle_now) m_st = 255;
    end else if (m_ph == 2 && idle_now) begin
      m_ph = 3;
      m_st = 255;
    end
  endtask

  initial begin
    tbl[0]  = '{1,1,0,0,0,1,0, 0,0,0,0};
    tbl[1]  = '{1,1,0,0,0,1,0, 0,0,0,0};
    tbl[2]  = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[3]  = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[4]  = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[5]  = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[6]  = '{0,0,0,0,0,1,0, 0,0,1,0};
    tbl[7]  = '{0,1,0,0,0,1,0, 1,0,0,0};
    tbl[8]  = '{0,1,0,0,0,1,0, 2,0,0,0};
    tbl[9]  = '{0,1,0,0,0,1,0, 3,0,0,0};
    tbl[10] = '{0,1,1,0,0,1,0, 3,0,0,0};
    tbl[11] = '{0,0,1,0,0,1,0, 2,0,0,0};
    tbl[12] = '{0,0,1,0,0,1,0, 1,0,0,0};
    tbl[13] = '{0,0,1,0,0,1,0, 0,0,0,0};
    tbl[14] = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[15] = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[16] = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[17] = '{0,0,0,0,0,1,0, 0,0,1,0};
    tbl[18] = '{0,0,0,1,0,1,0, 0,1,0,0};
    tbl[19] = '{0,0,0,1,0,1,0, 0,2,0,0};
    tbl[20] = '{0,0,0,0,0,1,1, 0,2,0,0};
    tbl[21] = '{0,0,0,0,1,1,0, 0,1,0,0};
    tbl[22] = '{0,0,0,0,1,1,0, 0,0,0,0};
    tbl[23] = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[24] = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[25] = '{0,0,0,0,0,1,0, 0,0,0,0};
    tbl[26] = '{0,0,0,0,0,1,0, 0,0,1,0};
    tbl[27] = '{0,0,0,0,0,1,0, 0,0,1,255};
    tbl[28] = '{0,0,0,0,0,1,0, 0,0,1,255};

    reset = 1;
    repeat (5) tick();
    chk("reset_rd", int'(rd_m), 0);
    chk("reset_idle", int'(idle_m), 0);
    chk("reset_status", int'(st_m), 0);
    reset = 0;
    for (int i = 0; i < 29; i++) begin
      {initFlag, rd_issue, rd_done, wr_issue, wr_done, progress, quit_req} =
        {tbl[i].ini, tbl[i].ri, tbl[i].rd, tbl[i].wi, tbl[i].wd, tbl[i].pg, tbl[i].q};
      tick();
      chk($sformatf("row%0d_rd", i), int'(rd_m), tbl[i].e_rd);
      chk($sformatf("row%0d_wr", i), int'(wr_m), tbl[i].e_wr);
      chk($sformatf("row%0d_idle", i), int'(idle_m), tbl[i].e_idle);
      chk($sformatf("row%0d_status", i), int'(st_m), tbl[i].e_st);
    end

    start();
    progress = 0;
    repeat (99) tick();
    chk("wd_99_status", int'(st_w), 0);
    tick();
    chk("wd_100_status", int'(st_w), 1);
    chk("wd_100_state", int'(dut_w.state_q), int'(ERROR));

    start();
    progress = 0;
    repeat (99) tick();
    progress = 1;
    tick();
    chk("wd_progress_status", int'(st_w), 0);
    progress = 0;
    repeat (5) tick();
    chk("wd_restart_status", int'(st_w), 0);

    start();
    rd_issue = 1;
    tick();
    rd_issue = 0;
    quit_req = 1;
    tick();
    quit_req = 0;
    chk("drain_state", int'(dut_w.state_q), int'(DRAIN));
    repeat (19) tick();
    chk("drain_19_status", int'(st_w), 0);
    tick();
    chk("drain_20_status", int'(st_w), 4);

    start();
    rd_done = 1;
    tick();
    rd_done = 0;
    chk("underflow_status", int'(st_m), 3);
    chk("underflow_idle", int'(idle_m), 0);

    start();
    wr_issue = 1;
    repeat (3) tick();
    chk("ovf_wr3", int'(wr_c), 3);
    chk("ovf_pre_status", int'(st_c), 0);
    tick();
    chk("ovf_status", int'(st_c), 2);
    chk("ovf_hold", int'(wr_c), 3);

    start();
    wr_issue = 1;
    repeat (3) tick();
    rd_done = 1;
    tick();
    clr();
    chk("both_err_status", int'(st_c), 2);
    chk("main_unf_status", int'(st_m), 3);

    start();
    wr_issue = 1;
    repeat (5) tick();
    wr_issue = 0;
    quit_req = 1;
    tick();
    quit_req = 0;
    chk("rst_drain_wr", int'(wr_m), 5);
    chk("rst_drain_state", int'(dut.state_q), int'(DRAIN));
    reset = 1;
    tick();
    chk("rst_wr", int'(wr_m), 0);
    chk("rst_rd", int'(rd_m), 0);
    chk("rst_status", int'(st_m), 0);
    chk("rst_idle", int'(idle_m), 0);
    chk("rst_state", int'(dut.state_q), int'(INIT));

    for (int ep = 0; ep < 20; ep++) begin
      int init_len;
      clr();
      reset = 1;
      initFlag = 1;
      repeat (2) tick();
      reset = 0;
      model_reset();
      init_len = int'($urandom_range(0, 3));
      for (int c = 0; c < 200; c++) begin
        initFlag = c < init_len;
        rd_issue = ($urandom % 4) == 0;
        rd_done  = m_rd > 0 ? ($urandom % 3) == 0 : ($urandom % 60) == 0;
        wr_issue = ($urandom % 4) == 0;
        wr_done  = m_wr > 0 ? ($urandom % 3) == 0 : ($urandom % 60) == 0;
        progress = ($urandom % 4) != 0;
        quit_req = ($urandom % 50) == 0;
        model_step(initFlag, rd_issue, rd_done, wr_issue, wr_done, progress, quit_req);
        tick();
        chk($sformatf("rand%0d_%0d_rd", ep, c), int'(rd_m), m_rd);
        chk($sformatf("rand%0d_%0d_wr", ep, c), int'(wr_m), m_wr);
        chk($sformatf("rand%0d_%0d_idle", ep, c), int'(idle_m), int'(model_idle()));
        chk($sformatf("rand%0d_%0d_status", ep, c), int'(st_m), m_st);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
